// File: rtl/alu_mult_pkg.sv
// Shared definitions for the ALU sequential multiplier: FSM states, default width
// and the result-mux selection code the control unit uses to pick the product.
package alu_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int          MULT_WIDTH = 8;
  localparam logic [2:0]  ALUOP_MUL  = 3'b100;

endpackage

// File: rtl/alu_mult_seq.sv
// Shift-add multiplier, one multiplier bit per clock; DONE WIDTH+1 edges after START.
// No backpressure: START is ignored while BUSY, and a new START is accepted in the DONE cycle.
module alu_mult_seq
  import alu_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 load;
  logic                 last;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign load     = (state != RUN) && START;
  assign last     = (state == RUN) && (count == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (count == '0) state_nxt = FIN;
      FIN:     state_nxt = START ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so START never reaches BUSY combinationally.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      RUN:     BUSY = 1'b1;
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      RESULT   <= '0;
      OVERFLOW <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, DATA1};
      mplier <= DATA2;
      count  <= CW'(WIDTH - 1);
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count != '0) begin
        count <= count - CW'(1);
      end
      // Result registers only move on the final iteration, keeping the result mux input stable.
      if (last) begin
        RESULT   <= acc_next[WIDTH-1:0];
        OVERFLOW <= |acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed-vector bench for alu_mult_seq: latency, overflow, ignored START, reset abort, back-to-back.
module tb_alu_mult_seq;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [7:0] RESULT;
  logic       OVERFLOW;
  logic       BUSY;
  logic       DONE;

  int vectors;
  int miscompares;

  alu_mult_seq #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .RESULT   (RESULT),
    .OVERFLOW (OVERFLOW),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    DATA1 = a;
    DATA2 = b;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic busy_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk1({tag, "_busy"}, BUSY, 1'b1);
      chk1({tag, "_nodone"}, DONE, 1'b0);
      step();
    end
  endtask

  task automatic chk_done(input string tag, input logic [7:0] res, input logic ovf);
    chk1({tag, "_done"}, DONE, 1'b1);
    chk1({tag, "_idle"}, BUSY, 1'b0);
    chk8({tag, "_result"}, RESULT, res);
    chk1({tag, "_ovf"}, OVERFLOW, ovf);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic ovf);
    accept(a, b);
    busy_steps(tag, 8);
    chk_done(tag, res, ovf);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET = 1'b1;
    START = 1'b0;
    DATA1 = 8'h00;
    DATA2 = 8'h00;
    step();
    step();
    RESET = 1'b0;
    chk8("rst_result", RESULT, 8'h00);
    chk1("rst_ovf", OVERFLOW, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_done", DONE, 1'b0);

    // 13*11 = 143
    run_op("basic", 8'd13, 8'd11, 8'h8F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk8("basic_hold", RESULT, 8'h8F);
      chk1("basic_single_done", DONE, 1'b0);
    end

    // 255*255 = 0xFE01; 253*5 = 0x4F1
    run_op("ovf", 8'hFF, 8'hFF, 8'h01, 1'b1);
    step();
    run_op("signed", 8'hFD, 8'h05, 8'hF1, 1'b1);
    step();
    run_op("zero", 8'h00, 8'hA7, 8'h00, 1'b0);
    step();

    // 9*9 = 0x51; a 2*3 START mid-run must be dropped
    accept(8'd9, 8'd9);
    busy_steps("ign", 3);
    DATA1 = 8'd2;
    DATA2 = 8'd3;
    START = 1'b1;
    chk1("ign_busy", BUSY, 1'b1);
    step();
    START = 1'b0;
    busy_steps("ign", 4);
    chk_done("ign", 8'h51, 1'b0);
    step();
    chk1("ign_one_done", DONE, 1'b0);
    chk1("ign_not_requeued", BUSY, 1'b0);
    chk8("ign_hold", RESULT, 8'h51);

    // Abort 200*3 in its 4th RUN cycle
    accept(8'd200, 8'd3);
    busy_steps("abort", 3);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk1("abort_busy", BUSY, 1'b0);
    chk8("abort_result", RESULT, 8'h00);
    chk1("abort_ovf", OVERFLOW, 1'b0);
    chk1("abort_done", DONE, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk1("abort_no_done", DONE, 1'b0);
    end
    run_op("after_abort", 8'd6, 8'd7, 8'h2A, 1'b0);
    step();

    // 3*4 then 5*5 accepted in the DONE cycle
    run_op("b2b_first", 8'd3, 8'd4, 8'h0C, 1'b0);
    accept(8'd5, 8'd5);
    chk8("b2b_result_stable", RESULT, 8'h0C);
    busy_steps("b2b_second", 8);
    chk_done("b2b_second", 8'h19, 1'b0);
    step();
    chk1("b2b_end_done", DONE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
